// File: rtl/vic_sound_pkg.sv
// Shared constants for the VIC sound block: register offsets, LFSR shape and
// voice counter width.
package vic_sound_pkg;

  localparam logic [3:0] REG_BASS  = 4'hA;
  localparam logic [3:0] REG_ALTO  = 4'hB;
  localparam logic [3:0] REG_SOP   = 4'hC;
  localparam logic [3:0] REG_NOISE = 4'hD;
  localparam logic [3:0] REG_VOL   = 4'hE;

  localparam int unsigned LFSR_W      = 15;
  localparam int unsigned LFSR_TAP_HI = 14;
  localparam int unsigned LFSR_TAP_LO = 13;

  localparam int unsigned CNT_W = 7;

  // Voice slots: 0 bass, 1 alto, 2 soprano, 3 noise.
  localparam logic [3:0] NOISE_MASK = 4'b1000;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/vic_sound_voice.sv
// One VIC voice: 7-bit up-counter reloaded from X, output bit toggled (or set
// from the noise source) on every reload.
module vic_sound_voice
  import vic_sound_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       strobe_i,
  input  logic [7:0] ctrl_i,
  input  logic       noise_mode_i,
  input  logic       noise_bit_i,
  output logic       q_o,
  output logic       reload_o
);

  logic             en;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;

  assign en = ctrl_i[7];
  assign x  = ctrl_i[CNT_W-1:0];

  assign reload_o = strobe_i & en & (&cnt_q);

  always_comb begin
    cnt_d = cnt_q;
    q_d   = q_q;
    if (strobe_i) begin
      if (!en) begin
        cnt_d = x;
        q_d   = 1'b0;
      end else if (&cnt_q) begin
        cnt_d = x;
        q_d   = noise_mode_i ? noise_bit_i : ~q_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/vic_sound.sv
// VIC 6560 sound section: register file at $900A-$900E, tick prescaler,
// three tone voices, one noise voice and a volume-scaled mixer.
module vic_sound
  import vic_sound_pkg::*;
#(
  parameter int unsigned       PRESCALE_SHIFT = 0,
  parameter logic [LFSR_W-1:0] LFSR_SEED      = 15'h7FFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clken,
  input  logic       cs,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [3:0] audio,
  output logic [3:0] voice_dbg
);

  localparam int unsigned DivW = 5 + PRESCALE_SHIFT;

  logic [4:0][7:0]    reg_q, reg_d;
  logic [DivW-1:0]    div_q, div_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d, lfsr_nxt;
  logic [3:0]         audio_q, audio_d;
  logic [3:0]         dbg_q;
  logic [3:0]         strobe, q, reload;
  logic               hi_ok, noise_bit, lfsr_step;
  logic [2:0]         n_high;
  logic [5:0]         mix;

  always_comb begin
    reg_d = reg_q;
    if (cs && we) begin
      case (addr)
        REG_BASS:  reg_d[0] = din;
        REG_ALTO:  reg_d[1] = din;
        REG_SOP:   reg_d[2] = din;
        REG_NOISE: reg_d[3] = din;
        REG_VOL:   reg_d[4] = din;
        default:   ;
      endcase
    end
  end

  always_comb begin
    dout = 8'h00;
    case (addr)
      REG_BASS:  dout = reg_q[0];
      REG_ALTO:  dout = reg_q[1];
      REG_SOP:   dout = reg_q[2];
      REG_NOISE: dout = reg_q[3];
      REG_VOL:   dout = reg_q[4];
      default:   ;
    endcase
  end

  // Extra prescale bits sit above the 5-bit voice divider.
  if (PRESCALE_SHIFT > 0) begin : g_hi
    assign hi_ok = &div_q[DivW-1:5];
  end else begin : g_nohi
    assign hi_ok = 1'b1;
  end

  assign div_d     = clken ? div_q + 1'b1 : div_q;
  assign strobe[0] = clken & hi_ok & (&div_q[3:0]);
  assign strobe[1] = clken & hi_ok & (&div_q[2:0]);
  assign strobe[2] = clken & hi_ok & (&div_q[1:0]);
  assign strobe[3] = clken & hi_ok & (&div_q[4:0]);

  assign lfsr_nxt  = lfsr_next(lfsr_q);
  assign noise_bit = lfsr_nxt[0];
  assign lfsr_step = |(reload & NOISE_MASK);
  assign lfsr_d    = lfsr_step ? lfsr_nxt : lfsr_q;

  for (genvar v = 0; v < 4; v++) begin : g_voice
    vic_sound_voice u_voice (
      .clk_i       (clk),
      .rst_i       (reset),
      .strobe_i    (strobe[v]),
      .ctrl_i      (reg_q[v]),
      .noise_mode_i(v == 3),
      .noise_bit_i (noise_bit),
      .q_o         (q[v]),
      .reload_o    (reload[v])
    );
  end

  always_comb begin
    n_high  = 3'(q[0]) + 3'(q[1]) + 3'(q[2]) + 3'(q[3]);
    mix     = 6'(n_high) * 6'(reg_q[4][3:0]);
    audio_d = 4'(mix >> 2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_q   <= '0;
      div_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      audio_q <= '0;
      dbg_q   <= '0;
    end else begin
      reg_q   <= reg_d;
      div_q   <= div_d;
      lfsr_q  <= lfsr_d;
      audio_q <= audio_d;
      dbg_q   <= q;
    end
  end

  assign audio     = audio_q;
  assign voice_dbg = dbg_q;

endmodule
